// File: rtl/mem_load_return_pkg.sv
// Shared memory-path constants: access width codes, load-return FSM states and
// the latched load request descriptor.
package mem_load_return_pkg;

  localparam int unsigned DataWidth = 32;

  // Width codes shared with the store path.
  typedef enum logic [1:0] {
    MemWidth4 = 2'b00,
    MemWidth2 = 2'b01,
    MemWidth1 = 2'b10
  } mem_width_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StHold = 2'b10
  } load_state_e;

  typedef struct packed {
    logic [1:0] width;
    logic       is_signed;
    logic [1:0] addr_lo;
  } load_req_t;

endpackage

// File: rtl/mem_load_return_if.sv
// Load request / SRAM read data / load result bundle between the pipeline and
// the load-return block.
interface mem_load_return_if;
  import mem_load_return_pkg::*;

  logic                 req_valid;
  logic [1:0]           req_width;
  logic                 req_signed;
  logic [1:0]           req_addr_lo;
  logic                 stall;
  logic                 flush;
  logic [DataWidth-1:0] data_sram_rdata;
  logic                 load_valid;
  logic [DataWidth-1:0] load_data;

  modport master (
    output req_valid, req_width, req_signed, req_addr_lo, stall, flush, data_sram_rdata,
    input  load_valid, load_data
  );

  modport slave (
    input  req_valid, req_width, req_signed, req_addr_lo, stall, flush, data_sram_rdata,
    output load_valid, load_data
  );

endinterface

// File: rtl/load_extract.sv
// Byte/halfword lane select and sign/zero extension of an SRAM read word.
module load_extract
  import mem_load_return_pkg::*;
(
  input  logic [DataWidth-1:0] rdata,
  input  logic [1:0]           width,
  input  logic                 is_signed,
  input  logic [1:0]           addr_lo,
  output logic [DataWidth-1:0] result
);

  logic [15:0] sel_half;
  logic [7:0]  sel_byte;

  always_comb begin
    sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase

    // The unused code 2'b11 falls back to a full-word load.
    case (mem_width_e'(width))
      MemWidth2: result = {{16{is_signed & sel_half[15]}}, sel_half};
      MemWidth1: result = {{24{is_signed & sel_byte[7]}}, sel_byte};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_return.sv
// Load return path: aligns and extends the SRAM read word one cycle after the
// request, holding the result while the consuming stage is stalled.
module mem_load_return
  import mem_load_return_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mem_load_return_if.slave  bus
);

  load_state_e          state_q, state_d;
  load_req_t            req_q;
  logic [DataWidth-1:0] hold_q;
  logic [DataWidth-1:0] extract_result;
  logic                 sample;
  logic                 accept;
  logic                 hold_en;

  assign sample = ~bus.stall & ~bus.flush;
  assign accept = bus.req_valid & sample;

  load_extract u_load_extract (
    .rdata     (bus.data_sram_rdata),
    .width     (req_q.width),
    .is_signed (req_q.is_signed),
    .addr_lo   (req_q.addr_lo),
    .result    (extract_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      req_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (sample) begin
        req_q <= '{width: bus.req_width, is_signed: bus.req_signed, addr_lo: bus.req_addr_lo};
      end
      if (hold_en) begin
        hold_q <= extract_result;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    hold_en        = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;

    case (state_q)
      StIdle: begin
        if (accept) state_d = StWait;
      end
      StWait: begin
        bus.load_valid = 1'b1;
        bus.load_data  = extract_result;
        if (bus.stall) begin
          hold_en = 1'b1;
          state_d = StHold;
        end else begin
          state_d = accept ? StWait : StIdle;
        end
      end
      StHold: begin
        bus.load_valid = 1'b1;
        bus.load_data  = hold_q;
        if (!bus.stall) state_d = accept ? StWait : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flush overrides stall and kills both the in-flight and the held result.
    if (bus.flush) begin
      state_d        = StIdle;
      hold_en        = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
    end
  end

endmodule

// File: doc/mem_load_return.md
MEM_LOAD_RETURN -- requirements
Module: mem_load_return

Interface
REQ-001 Parameter: none; widths are fixed at 32-bit data and 2-bit width code.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  load issued to data SRAM this cycle, already exception-free.
REQ-005 req_width  input  2  memWidth4 / memWidth2 / memWidth1, using the same encoding as the store path.
REQ-006 req_signed  input  1  1 = sign-extend sub-word result, 0 = zero-extend.
REQ-007 req_addr_lo  input  2  address[1:0] of the load.
REQ-008 stall  input  1  consuming stage frozen this cycle.
REQ-009 flush  input  1  discard any in-flight or held load.
REQ-010 data_sram_rdata  input  32  SRAM read word, valid exactly one cycle after the request cycle.
REQ-011 load_valid  output  1  load_data holds a completed load this cycle.
REQ-012 load_data  output  32  aligned, extended load result.

Function
REQ-013 The block SHALL use a three-state FSM: IDLE, WAIT (SRAM data arriving this cycle) and HOLD (result captured, consumer stalled).
REQ-014 The block SHALL sample req_valid/req_width/req_signed/req_addr_lo only when stall=0 and flush=0, and SHALL latch them into a request register on that edge.
REQ-015 IDLE SHALL go to WAIT on an accepted request; otherwise it SHALL stay in IDLE.
REQ-016 In WAIT with stall=0, the block SHALL assert load_valid and drive load_data combinationally from data_sram_rdata; the next state is WAIT on a new accepted request, else IDLE.
REQ-017 In WAIT with stall=1, the block SHALL capture the aligned result into a hold register, SHALL assert load_valid, and the next state is HOLD.
REQ-018 In HOLD, the block SHALL drive load_data from the hold register with load_valid=1; it SHALL stay in HOLD while stall=1 and leave per REQ-016 rules when stall=0.
REQ-019 In IDLE, load_valid SHALL be 0 and load_data SHALL be 0.
REQ-020 Word loads SHALL return rdata unchanged and SHALL ignore addr_lo.
REQ-021 Halfword loads SHALL select rdata[31:16] when addr_lo[1]=1, else rdata[15:0], then extend per req_signed.
REQ-022 Byte loads SHALL select byte lane addr_lo (lane 0 = rdata[7:0], lane 3 = rdata[31:24]), then extend per req_signed.
REQ-023 flush=1 SHALL force the next state to IDLE from any state, SHALL force load_valid=0 in the same cycle, and SHALL block request acceptance on that edge.
REQ-024 When flush and stall are both 1, flush SHALL win.
REQ-025 Back-to-back loads (a request accepted every cycle with stall=0) SHALL produce one load_valid per cycle with no bubble.

Reset
REQ-026 While reset=0, the FSM SHALL be IDLE and the request and hold registers SHALL be 0, so load_valid=0 and load_data=0.
REQ-027 Reset asserted mid-load SHALL drop that load with no later load_valid; the first request after deassertion SHALL be accepted normally.

Structure
REQ-028 Width codes (memWidth1/2/4) and the FSM state enum SHALL live in the shared constants package used by the store path.
REQ-029 Lane select and extension SHALL be one combinational sub-module, load_extract (inputs: rdata, width, signed, addr_lo; output: 32-bit result), instantiated once; the hold register is written from its output.

Verification
REQ-030 Word load, rdata=0xDEADBEEF, stall=0 -> load_valid=1 and load_data=0xDEADBEEF one cycle after the request.
REQ-031 Signed byte, addr_lo=3, rdata=0x80123456 -> 0xFFFFFF80; same unsigned -> 0x00000080; halfword signed addr_lo=2 -> 0xFFFF8012.
REQ-032 Halfword unsigned addr_lo=0, rdata=0x1234ABCD, stall=1 for 3 cycles starting in the WAIT cycle, rdata changed to 0 meanwhile -> load_data=0x0000ABCD with load_valid=1 for all 4 cycles.
REQ-033 Three back-to-back word loads 0x1, 0x2, 0x3 -> load_valid on 3 consecutive cycles with those values in order.
REQ-034 flush asserted in WAIT, and separately in HOLD with stall=1 -> load_valid=0 that cycle and the FSM is IDLE next cycle.
REQ-035 reset driven low asynchronously in WAIT -> load_valid=0 immediately; no load_valid after release until a new request.
